// File: rtl/hazard_stall_ctrl.sv
// ---------------------------------------------------------------------------
// hazard_stall_ctrl
//
// Pipeline hazard and stall controller. It looks at the ID/EX register's
// registered MemRead / RT outputs and at the MEM-stage memory handshake, and
// drives the write-enable, bubble, flush and hold controls back into PC,
// IF/ID, ID/EX and EX/MEM-MEM/WB.
//
//   - Load-use hazard : the load in EX targets a register read by ID, so a
//                       bubble goes into ID/EX and PC / IF/ID are frozen.
//   - Memory freeze   : data memory is not ready, so the whole pipeline
//                       holds. A timeout FSM bounds the wait and sets a
//                       sticky error flag when it fires.
//   - Branch flush    : a taken branch in ID clears IF/ID.
//
// Ports
//   clk_i, rst_i              clock (rising edge), async active-low reset
//   id_rs_addr_i/id_rt_addr_i source fields of the instruction in ID
//   id_uses_rt_i              ID instruction reads rt as a source
//   ex_memread_i/ex_rt_addr_i ID/EX MemRead and load destination
//   mem_req_i/mem_ready_i     MEM-stage request and memory completion
//   branch_taken_i            branch resolved taken in ID
//   pc_write_o .. exmem_hold_o pipeline controls (combinational)
//   state_o                   0 = RUN, 1 = MEM_WAIT
//   mem_err_o                 sticky memory-timeout flag
//   stall_cnt_o               saturating count of cycles with pc_write_o=0
//   lu_cnt_o                  saturating count of load-use bubbles
// ---------------------------------------------------------------------------
module hazard_stall_ctrl #(
    parameter int unsigned MEM_TIMEOUT = 16,
    parameter int unsigned CNT_W       = 16
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic [4:0]       id_rs_addr_i,
    input  logic [4:0]       id_rt_addr_i,
    input  logic             id_uses_rt_i,
    input  logic             ex_memread_i,
    input  logic [4:0]       ex_rt_addr_i,
    input  logic             mem_req_i,
    input  logic             mem_ready_i,
    input  logic             branch_taken_i,
    output logic             pc_write_o,
    output logic             ifid_write_o,
    output logic             ifid_flush_o,
    output logic             idex_write_o,
    output logic             idex_bubble_o,
    output logic             exmem_hold_o,
    output logic [1:0]       state_o,
    output logic             mem_err_o,
    output logic [CNT_W-1:0] stall_cnt_o,
    output logic [CNT_W-1:0] lu_cnt_o
);

    typedef enum logic [1:0] {
        ST_RUN      = 2'd0,
        ST_MEM_WAIT = 2'd1
    } state_t;

    // wait_cnt never exceeds MEM_TIMEOUT-1 (<= 254), so 8 bits suffice.
    localparam logic [7:0]       WAIT_LAST = 8'(MEM_TIMEOUT - 1);
    localparam logic [CNT_W-1:0] CNT_MAX   = {CNT_W{1'b1}};

    state_t           state_r;
    logic [7:0]       wait_cnt_r;
    logic             mem_err_r;
    logic [CNT_W-1:0] stall_cnt_r;
    logic [CNT_W-1:0] lu_cnt_r;

    logic             lu_s;
    logic             timeout_s;
    logic             frz_s;
    logic             lu_sel_s;

    // Counter increment that holds at all-ones instead of wrapping.
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        if (v == CNT_MAX) begin
            sat_inc = v;
        end else begin
            sat_inc = v + {{(CNT_W-1){1'b0}}, 1'b1};
        end
    endfunction

    // Hazard detection: register 0 is hardwired, so it never creates a hazard.
    always_comb begin
        lu_s = ex_memread_i & (ex_rt_addr_i != 5'd0) &
               ((ex_rt_addr_i == id_rs_addr_i) |
                (id_uses_rt_i & (ex_rt_addr_i == id_rt_addr_i)));
    end

    // Freeze decision; in MEM_WAIT the freeze drops on ready or on timeout.
    always_comb begin
        timeout_s = 1'b0;
        frz_s     = 1'b0;
        case (state_r)
            ST_RUN: begin
                frz_s = mem_req_i & ~mem_ready_i;
            end
            ST_MEM_WAIT: begin
                timeout_s = ~mem_ready_i & (wait_cnt_r == WAIT_LAST);
                frz_s     = ~mem_ready_i & (wait_cnt_r != WAIT_LAST);
            end
            default: begin
                timeout_s = 1'b0;
                frz_s     = 1'b0;
            end
        endcase
    end

    // Priority encoder for the pipeline controls: freeze > load-use > branch.
    always_comb begin
        pc_write_o    = 1'b0;
        ifid_write_o  = 1'b0;
        ifid_flush_o  = 1'b0;
        idex_write_o  = 1'b0;
        idex_bubble_o = 1'b0;
        exmem_hold_o  = 1'b0;
        lu_sel_s      = 1'b0;
        if (!rst_i) begin
            // Everything stays quiet while the block is held in reset.
            lu_sel_s = 1'b0;
        end else if (frz_s) begin
            exmem_hold_o = 1'b1;
        end else if (lu_s) begin
            // A taken branch is ignored here; it is seen again next cycle.
            idex_write_o  = 1'b1;
            idex_bubble_o = 1'b1;
            lu_sel_s      = 1'b1;
        end else if (branch_taken_i) begin
            pc_write_o   = 1'b1;
            ifid_write_o = 1'b1;
            idex_write_o = 1'b1;
            ifid_flush_o = 1'b1;
        end else begin
            pc_write_o   = 1'b1;
            ifid_write_o = 1'b1;
            idex_write_o = 1'b1;
        end
    end

    // Memory-wait FSM with bounded wait and sticky timeout flag.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_r    <= ST_RUN;
            wait_cnt_r <= 8'd0;
            mem_err_r  <= 1'b0;
        end else begin
            case (state_r)
                ST_RUN: begin
                    if (mem_req_i && !mem_ready_i) begin
                        state_r    <= ST_MEM_WAIT;
                        wait_cnt_r <= 8'd1;
                    end else begin
                        state_r    <= ST_RUN;
                        wait_cnt_r <= 8'd0;
                    end
                end
                ST_MEM_WAIT: begin
                    if (mem_ready_i) begin
                        state_r    <= ST_RUN;
                        wait_cnt_r <= 8'd0;
                    end else if (timeout_s) begin
                        state_r    <= ST_RUN;
                        wait_cnt_r <= 8'd0;
                        mem_err_r  <= 1'b1;
                    end else begin
                        wait_cnt_r <= wait_cnt_r + 8'd1;
                    end
                end
                default: begin
                    state_r    <= ST_RUN;
                    wait_cnt_r <= 8'd0;
                end
            endcase
        end
    end

    // Saturating performance counters for stall cycles and load-use bubbles.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            stall_cnt_r <= {CNT_W{1'b0}};
            lu_cnt_r    <= {CNT_W{1'b0}};
        end else begin
            if (!pc_write_o) begin
                stall_cnt_r <= sat_inc(stall_cnt_r);
            end
            if (lu_sel_s) begin
                lu_cnt_r <= sat_inc(lu_cnt_r);
            end
        end
    end

    assign state_o     = state_r;
    assign mem_err_o   = mem_err_r;
    assign stall_cnt_o = stall_cnt_r;
    assign lu_cnt_o    = lu_cnt_r;

endmodule
